// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter
//   Shares the single-port sprite RAM between the command-parser write stream
//   and the renderer read port. Parser writes are buffered in a small FIFO and
//   the renderer normally wins. Buffered writes are forced out when the FIFO is
//   full or when its head has waited MAX_WAIT cycles.
//
// Ports
//   clock, reset_n                     clock, async active-low reset
//   wr_en/wr_sprite/wr_addr/wr_data    one-cycle write request (buffered)
//   wr_overflow                        sticky: a write was dropped (FIFO full)
//   fifo_level                         current FIFO occupancy
//   rd_req/rd_sprite/rd_addr           renderer read, held until rd_gnt
//   rd_gnt                             combinational: read accepted this cycle
//   rd_valid/rd_data                   read result, 3 cycles after rd_gnt
//   mem_en/mem_we/mem_sprite/
//   mem_addr/mem_wdata                 registered RAM access
//   mem_rdata                          RAM read data, 1 cycle after read strobe
//   stall_count                        cycles with rd_req & !rd_gnt
//
// Optional feature macro: SPRITE_ARB_STATS_EN enables the saturating 16-bit
// stall counter; without it stall_count is tied to 0.
module sprite_mem_arbiter #(
  parameter int SEL_W      = 3,
  parameter int ADDR_W     = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          wr_en,
  input  logic [SEL_W-1:0]              wr_sprite,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [7:0]                    wr_data,
  output logic                          wr_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          rd_req,
  input  logic [SEL_W-1:0]              rd_sprite,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic                          rd_gnt,
  output logic                          rd_valid,
  output logic [7:0]                    rd_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [SEL_W-1:0]              mem_sprite,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [7:0]                    mem_wdata,
  input  logic [7:0]                    mem_rdata,
  output logic [15:0]                   stall_count
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = $clog2(MAX_WAIT + 1);
  // vld_pipe_q[0]: RAM read strobe, [1]: mem_rdata valid, [2]: rd_valid
  localparam int RD_STAGES = 2;

  typedef struct packed {
    logic [SEL_W-1:0]  sprite;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_req_t;

  wr_req_t              fifo_q [FIFO_DEPTH];
  logic [PTR_W:0]       wptr_q, rptr_q;
  logic [CNT_W-1:0]     wait_q, wait_d;
  logic                 ovf_q, ovf_d;
  logic [RD_STAGES:0]   vld_pipe_q;
  logic [7:0]           rd_data_q;
  logic                 mem_en_q, mem_we_q;
  logic [SEL_W-1:0]     mem_sprite_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [7:0]           mem_wdata_q;

  logic                 full, empty, force_wr, push, pop;
  logic [PTR_W:0]       level;
  wr_req_t              head;

  // Extra pointer bit distinguishes full from empty.
  assign level    = wptr_q - rptr_q;
  assign full     = (level == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign head     = fifo_q[rptr_q[PTR_W-1:0]];

  assign force_wr = full | (wait_q >= CNT_W'(MAX_WAIT));
  assign rd_gnt   = rd_req & ~force_wr;
  assign pop      = ~rd_gnt & ~empty;
  // Fullness is judged at the start of the cycle: a same-cycle pop does not
  // make room for the incoming write.
  assign push     = wr_en & ~full;

  always_comb begin
    wait_d = wait_q;
    if (empty | pop)
      wait_d = '0;
    else if (wait_q < CNT_W'(MAX_WAIT))
      wait_d = wait_q + 1'b1;
  end

  assign ovf_d = ovf_q | (wr_en & full);

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push)
      fifo_q[wptr_q[PTR_W-1:0]] <= '{sprite: wr_sprite, addr: wr_addr, data: wr_data};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      wait_q       <= '0;
      ovf_q        <= 1'b0;
      vld_pipe_q   <= '0;
      rd_data_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sprite_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      wait_q     <= wait_d;
      ovf_q      <= ovf_d;
      vld_pipe_q <= {vld_pipe_q[RD_STAGES-1:0], rd_gnt};
      if (vld_pipe_q[RD_STAGES-1])
        rd_data_q <= mem_rdata;
      mem_en_q <= rd_gnt | pop;
      mem_we_q <= pop;
      if (rd_gnt) begin
        mem_sprite_q <= rd_sprite;
        mem_addr_q   <= rd_addr;
      end else if (pop) begin
        mem_sprite_q <= head.sprite;
        mem_addr_q   <= head.addr;
        mem_wdata_q  <= head.data;
      end
    end
  end

  assign wr_overflow = ovf_q;
  assign fifo_level  = level;
  assign rd_valid    = vld_pipe_q[RD_STAGES];
  assign rd_data     = rd_data_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_sprite  = mem_sprite_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

`ifdef SPRITE_ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      stall_q <= '0;
    else if (rd_req & ~rd_gnt & (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule
